// File: rtl/imm_ext_unit_if.sv
// Request/response bundle for the immediate extension unit.
// The master drives requests and out_ready. The slave (the unit) drives
// in_ready and the registered result.
interface imm_ext_if #(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 3
);
  localparam int PFX_W = DATA_W - IMM_W;

  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  imm_in;
  logic [1:0]        mode;
  logic              is_pfx;
  logic [PFX_W-1:0]  pfx_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] imm_ext;
  logic              pfx_pending;
  logic              illegal;

  modport master (
    output in_valid, imm_in, mode, is_pfx, pfx_data, flush, out_ready,
    input  in_ready, out_valid, imm_ext, pfx_pending, illegal
  );

  modport slave (
    input  in_valid, imm_in, mode, is_pfx, pfx_data, flush, out_ready,
    output in_ready, out_valid, imm_ext, pfx_pending, illegal
  );
endinterface

// File: rtl/imm_ext_unit.sv
// Immediate extension unit.
// - Sign-extends, zero-extends or sign-extends-and-shifts a short immediate to DATA_W.
// - A prefix request latches its upper bits, and the next non-prefix request
//   concatenates the latched bits with its immediate.
// - The result sits in a single output register with a valid/ready handshake.
// - A flush drops the held result and any latched prefix.
module imm_ext_unit #(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 3
) (
  input logic      clk,
  input logic      reset,
  imm_ext_if.slave bus
);
  localparam int PFX_W = DATA_W - IMM_W;

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_PFX_HELD = 1'b1;

  logic [0:0]        r_state;
  logic [PFX_W-1:0]  r_pfx;
  logic [DATA_W-1:0] r_imm_ext;
  logic              r_out_valid;
  logic              r_illegal;

  logic              w_in_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_result;
  logic              w_illegal;

  // The output slot is free when it is empty or is being drained this cycle.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

  assign w_sext = {{PFX_W{bus.imm_in[IMM_W-1]}}, bus.imm_in};
  assign w_zext = {{PFX_W{1'b0}}, bus.imm_in};

  // Select the extended value. A latched prefix overrides the mode, so an
  // illegal mode is only flagged for a stand-alone immediate.
  always_comb begin
    w_result  = {DATA_W{1'b0}};
    w_illegal = 1'b0;
    if (r_state == S_PFX_HELD) begin
      w_result  = {r_pfx, bus.imm_in};
      w_illegal = 1'b0;
    end else begin
      case (bus.mode)
        2'b00: w_result = w_sext;
        2'b01: w_result = w_zext;
        2'b10: w_result = {w_sext[DATA_W-2:0], 1'b0};
        2'b11: begin
          w_result  = {DATA_W{1'b0}};
          w_illegal = 1'b1;
        end
        default: begin
          w_result  = {DATA_W{1'b0}};
          w_illegal = 1'b0;
        end
      endcase
    end
  end

  // Prefix tracking, result register and handshake; flush outranks everything but reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pfx       <= {PFX_W{1'b0}};
      r_imm_ext   <= {DATA_W{1'b0}};
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_pfx       <= {PFX_W{1'b0}};
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      if (bus.is_pfx) begin
        // A prefix produces no result; any previous result was drained
        // this cycle, because acceptance implies the slot is free.
        r_state     <= S_PFX_HELD;
        r_pfx       <= bus.pfx_data;
        r_out_valid <= 1'b0;
        r_illegal   <= 1'b0;
      end else begin
        r_state     <= S_IDLE;
        r_imm_ext   <= w_result;
        r_out_valid <= 1'b1;
        r_illegal   <= w_illegal;
      end
    end else begin
      // Without a new result, illegal is a single-cycle flag. It drops even
      // while the result it came with is being held.
      r_illegal <= 1'b0;
      if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.imm_ext     = r_imm_ext;
  assign bus.illegal     = r_illegal;
  assign bus.pfx_pending = (r_state == S_PFX_HELD);
endmodule

// File: tb/tb_imm_ext_unit.sv
// Scoreboard bench for imm_ext_unit.
// The driver applies directed cases and then random requests. Each accepted
// immediate's expected value, computed arithmetically, is queued. A separate
// monitor pops the queue whenever a fresh result appears on the output.
module tb_imm_ext_unit;
  localparam int DW = 8;
  localparam int IW = 3;
  localparam int PW = DW - IW;

  logic clk = 1'b0;
  logic reset;

  imm_ext_if #(.DATA_W(DW), .IMM_W(IW)) bus ();

  imm_ext_unit #(.DATA_W(DW), .IMM_W(IW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected results: bit DW is the illegal flag, bits DW-1:0 are imm_ext.
  logic [DW:0] exp_q[$];

  // Reference model state: is a result held, is a prefix waiting, prefix value.
  bit m_valid = 1'b0;
  bit m_held  = 1'b0;
  int m_pfx   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Extension rules done with integer arithmetic on the immediate's value.
  function automatic logic [DW-1:0] ref_ext(input int imm, input int md);
    int v;
    v = (imm >= (1 << (IW - 1))) ? imm - (1 << IW) : imm;
    case (md)
      0:       return DW'(v);
      1:       return DW'(imm);
      2:       return DW'(v * 2);
      default: return '0;
    endcase
  endfunction

  // One clock cycle of stimulus. Inputs are applied just after a rising
  // edge, checked mid-cycle, and the model is updated at the next edge.
  task automatic step(input bit v, input int imm, input int md, input bit p,
                      input int pd, input bit fl, input bit ordy);
    bit acc;
    bus.in_valid  = v;
    bus.imm_in    = IW'(imm);
    bus.mode      = 2'(md);
    bus.is_pfx    = p;
    bus.pfx_data  = PW'(pd);
    bus.flush     = fl;
    bus.out_ready = ordy;
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
    chk("pfx_pending", 32'(bus.pfx_pending), 32'(m_held));
    @(posedge clk);
    acc = v && !fl && (!m_valid || ordy);
    if (fl) begin
      m_valid = 1'b0;
      m_held  = 1'b0;
      m_pfx   = 0;
    end else if (acc && p) begin
      m_pfx   = pd & ((1 << PW) - 1);
      m_held  = 1'b1;
      m_valid = 1'b0;
    end else if (acc) begin
      if (m_held) exp_q.push_back({1'b0, DW'(m_pfx * (1 << IW) + imm)});
      else        exp_q.push_back({(md == 3), ref_ext(imm, md)});
      m_valid = 1'b1;
      m_held  = 1'b0;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, ordy);
  endtask

  // Assert reset between clock edges and check that it clears the outputs at once.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    reset        = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imm_ext", 32'(bus.imm_ext), 32'd0);
    chk("rst_pfx_pending", 32'(bus.pfx_pending), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    m_valid = 1'b0;
    m_held  = 1'b0;
    m_pfx   = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: a valid output following a free slot is a fresh result to score.
  // Otherwise the output must hold its last value and illegal must stay low.
  bit          mon_free  = 1'b1;
  bit          mon_flush = 1'b0;
  logic [DW-1:0] mon_last = '0;
  logic [DW:0]   mon_e;
  always @(negedge clk) begin
    if (reset) begin
      mon_free  = 1'b1;
      mon_flush = 1'b0;
      mon_last  = '0;
    end else begin
      if (mon_flush) chk("flush_clears_valid", 32'(bus.out_valid), 32'd0);
      if (!mon_flush && mon_free && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("imm_ext", 32'(bus.imm_ext), 32'(mon_e[DW-1:0]));
          chk("illegal", 32'(bus.illegal), 32'(mon_e[DW]));
          mon_last = mon_e[DW-1:0];
        end
      end else begin
        if (!mon_flush && !mon_free) chk("held_valid", 32'(bus.out_valid), 32'd1);
        if (!mon_flush && mon_free) chk("missing_result", 32'(exp_q.size()), 32'd0);
        chk("imm_ext_hold", 32'(bus.imm_ext), 32'(mon_last));
        chk("illegal_idle", 32'(bus.illegal), 32'd0);
      end
      mon_free  = !bus.out_valid || bus.out_ready;
      mon_flush = bus.flush;
    end
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.imm_in    = '0;
    bus.mode      = '0;
    bus.is_pfx    = 1'b0;
    bus.pfx_data  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("por_out_valid", 32'(bus.out_valid), 32'd0);
    chk("por_imm_ext", 32'(bus.imm_ext), 32'd0);
    chk("por_pfx_pending", 32'(bus.pfx_pending), 32'd0);
    chk("por_illegal", 32'(bus.illegal), 32'd0);
    reset = 1'b0;

    // Each extension mode, back to back: FD, 05, FC, then 00 with illegal set.
    step(1'b1, 5, 0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 5, 1, 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 6, 2, 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 5, 3, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b1);

    // Prefix 10110 followed by 011 with mode 10 gives B3.
    step(1'b1, 0, 0, 1'b1, 22, 1'b0, 1'b1);
    step(1'b1, 3, 2, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b1);

    // A second prefix overwrites the first; mode 11 is ignored under a prefix.
    step(1'b1, 0, 0, 1'b1, 1, 1'b0, 1'b1);
    step(1'b1, 0, 0, 1'b1, 31, 1'b0, 1'b1);
    step(1'b1, 0, 3, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b1);

    // Backpressure for three cycles with a request waiting, then release.
    step(1'b1, 2, 0, 1'b0, 0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 7, 1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 7, 1, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b1);

    // Flush with a simultaneous request drops both the prefix and the request.
    step(1'b1, 0, 0, 1'b1, 9, 1'b0, 1'b1);
    step(1'b1, 4, 0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b1, 7, 0, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b1);

    // Reset while a prefix is held; the next request behaves as from IDLE.
    step(1'b1, 0, 0, 1'b1, 9, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 7, 0, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b1);

    // Reset while a result is held under backpressure.
    step(1'b1, 1, 0, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b0);
    do_reset();
    step(1'b1, 6, 1, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b1);

    // Random traffic with flushes, backpressure and occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(3) != 0, int'($urandom_range(7)), int'($urandom_range(3)),
             $urandom_range(3) == 0, int'($urandom_range(31)),
             $urandom_range(9) == 0, $urandom_range(9) < 7);
      end
    end

    repeat (3) idle(1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
